// File: rtl/nn_pkg.sv
// Shared types and defaults for the neuron datapath blocks.
package nn_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } loader_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/neuron_input_loader.sv
// Serial-to-parallel loader: assembles a framed sample stream into a vector,
// strobes the neuron once per vector and holds the vector until it is done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | accepting samples into inputs[count]
// ISSUE     | vector complete, start strobe high for this one cycle
// WAIT_DONE | vector held stable until the neuron reports completion
module neuron_input_loader
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_INPUTS = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    output logic                         input_ready,
    input  logic                         neuron_done,
    output logic                         busy,
    output logic                         frame_error
);

    localparam int CW = $clog2(NUM_INPUTS);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_INPUTS - 1);

    loader_state_t state, next_state;
    logic [CW-1:0] count, next_count;
    logic          wr_en;
    logic          err;
    logic          accept;

    // in_ready is the only combinational output; reset gating keeps it low
    // for the whole reset interval rather than one cycle later.
    assign in_ready = reset && (state == FILL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        next_state = state;
        next_count = count;
        wr_en      = 1'b0;
        err        = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (count == LAST_SLOT) begin
                        next_count = '0;
                        if (in_last) begin
                            wr_en      = 1'b1;
                            next_state = ISSUE;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (in_last) begin
                        next_count = '0;
                        err        = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        next_count = count + CW'(1);
                    end
                end
            end
            ISSUE: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (neuron_done) begin
                    next_state = FILL;
                end
            end
            default: begin
                next_state = FILL;
                next_count = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= FILL;
            count       <= '0;
            input_ready <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                inputs[i] <= '0;
            end
        end else begin
            state       <= next_state;
            count       <= next_count;
            input_ready <= (next_state == ISSUE);
            busy        <= (next_state == ISSUE) || (next_state == WAIT_DONE);
            frame_error <= err;
            if (wr_en) begin
                inputs[count] <= in_data;
            end
        end
    end

endmodule
